// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift-add or restoring-subtract step per cycle, fixed latency for every op.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     counter;
    logic [2:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;

    logic              signed1;
    logic              signed2;
    logic              neg1;
    logic              neg2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_value;

    // Operand decode at Start: which operands are signed and their magnitudes.
    always_comb begin
        signed1 = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
        signed2 = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        neg1    = signed1 & Operand1[XLEN-1];
        neg2    = signed2 & Operand2[XLEN-1];
        mag1    = neg1 ? -Operand1 : Operand1;
        mag2    = neg2 ? -Operand2 : Operand2;
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {add_sum, acc[XLEN-1:1]};
        trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, operand};
        div_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Overflow (most negative / -1) falls out of the magnitude path; only divide-by-zero
    // needs an override, because its all-ones quotient must not be sign corrected.
    always_comb begin
        fixed     = neg_res ? -acc : acc;
        rem_fixed = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fix_value = acc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_value = fixed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_value = div_zero ? '1 : fixed[XLEN-1:0];
            default:                fix_value = rem_fixed;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            counter  <= '0;
            op       <= '0;
            acc      <= '0;
            operand  <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            Result   <= '0;
        end else if (Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op       <= Funct3;
                        neg_res  <= neg1 ^ neg2;
                        neg_rem  <= neg1;
                        div_zero <= (Operand2 == '0);
                        counter  <= '0;
                        if (Funct3[2]) begin
                            acc     <= {{XLEN{1'b0}}, mag1};
                            operand <= mag2;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, mag2};
                            operand <= mag1;
                        end
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc     <= op[2] ? div_next : mul_next;
                    counter <= counter + CW'(1);
                    if (counter == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result <= fix_value;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results queued at Start, checked at Done.
module tb_ex_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int          total_checks  = 0;
    int          passed_checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = '0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Funct3   (Funct3),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Flush    (Flush),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // Called 1ns after an edge; returns 1ns after the accepting edge with operands scrambled.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        Funct3   = f3;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        Funct3   = 3'($urandom);
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] expected);
        exp_q.push_back(expected);
        start_op(f3, a, b);
    endtask

    // first_cycle is the cycle count (after the accepting edge) at which we are entered.
    task automatic check_output(input string tag, input int first_cycle);
        int          n = first_cycle;
        int          busy_n = first_cycle - 1;
        logic [31:0] expected;
        while (Done !== 1'b1 && n < 60) begin
            if (Busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            n++;
        end
        if (Busy === 1'b1) busy_n++;
        check({tag, "_latency"}, n, 34);
        check({tag, "_busy_cycles"}, busy_n, 34);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            expected = exp_q.pop_front();
            check({tag, "_result"}, Result, expected);
            last_result = expected;
        end
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, Done, 0);
        check({tag, "_busy_after"}, Busy, 0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (Done === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        check({tag, "_no_done"}, seen, 0);
    endtask

    initial begin
        Start    = 1'b0;
        Flush    = 1'b0;
        Funct3   = '0;
        Operand1 = '0;
        Operand2 = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_result", Result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(OP_MUL, 32'd7, 32'd6, 32'h0000002A);
        check_output("mul_7x6", 1);

        apply_stimulus(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        check_output("mulh_m1", 1);
        apply_stimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        check_output("mulhu_max", 1);
        apply_stimulus(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_output("mulhsu_m1", 1);
        apply_stimulus(OP_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        check_output("mul_neg", 1);

        apply_stimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        check_output("div_m7_2", 1);
        apply_stimulus(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        check_output("rem_m7_2", 1);
        apply_stimulus(OP_DIVU, 32'd100, 32'd7, 32'd14);
        check_output("divu_100_7", 1);
        apply_stimulus(OP_REMU, 32'd100, 32'd7, 32'd2);
        check_output("remu_100_7", 1);

        apply_stimulus(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF);
        check_output("div_by0", 1);
        apply_stimulus(OP_REMU, 32'd5, 32'd0, 32'd5);
        check_output("remu_by0", 1);
        apply_stimulus(OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        check_output("rem_neg_by0", 1);
        apply_stimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        check_output("div_ovf", 1);
        apply_stimulus(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        check_output("rem_ovf", 1);

        // Flush in flight at cycle 10: no Done, Result keeps the previous value.
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        no_done("flush", 40);
        check("flush_result_held", Result, last_result);

        // Start and Flush together: nothing accepted.
        Funct3   = OP_MUL;
        Operand1 = 32'd11;
        Operand2 = 32'd13;
        Start    = 1'b1;
        Flush    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        check("start_flush_busy", Busy, 0);
        no_done("start_flush", 40);
        check("start_flush_result_held", Result, last_result);

        // A second Start at cycle 5 is ignored.
        apply_stimulus(OP_MUL, 32'd3, 32'd5, 32'd15);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        Funct3   = OP_DIVU;
        Operand1 = 32'd100;
        Operand2 = 32'd7;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        check_output("second_start", 6);
        no_done("second_start_extra", 40);

        // Asynchronous reset between edges in the middle of CALC.
        start_op(OP_MUL, 32'd1234, 32'd5678);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", Busy, 0);
        check("async_rst_done", Done, 0);
        check("async_rst_result", Result, 0);
        last_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        no_done("after_reset", 5);
        apply_stimulus(OP_MUL, 32'd3, 32'd3, 32'd9);
        check_output("mul_3x3", 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
